// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer: entry layout and drain policy codes.
package sb_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  localparam int DRAIN_EAGER = 0;
  localparam int DRAIN_LAZY  = 1;

  // Reference entry layout at the default widths; the top builds the same shape at its own widths.
  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_q_if.sv
// Core/cache-facing bundle of the store buffer: store intake, load lookup, cache drain and status.
interface store_buffer_q_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              dc_valid;
  logic              dc_ready;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_data;
  logic              drain_req;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, dc_ready, drain_req,
    input  st_ready, ld_hit, ld_data, dc_valid, dc_addr, dc_data, empty, full, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, dc_ready, drain_req,
    output st_ready, ld_hit, ld_data, dc_valid, dc_addr, dc_data, empty, full, count
  );

endinterface

// File: rtl/sb_fwd_match.sv
// Combinational store-to-load forwarding: scans entries oldest to youngest so the youngest match wins.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter int  ADDR_W  = SB_ADDR_W,
  parameter int  DATA_W  = SB_DATA_W,
  parameter type ENTRY_T = sb_entry_t
) (
  input  ENTRY_T                     i_entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   i_head,
  input  logic [ADDR_W-1:0]          i_ld_addr,
  output logic                       o_hit,
  output logic [DATA_W-1:0]          o_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  w_match;
  logic [DATA_W-1:0] w_data [DEPTH];

  // Slot gi of these vectors is the entry of age gi, i.e. index (head + gi) mod DEPTH.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PTR_W-1:0] w_idx;
    assign w_idx       = i_head + PTR_W'(gi);
    assign w_match[gi] = i_entries[w_idx].valid && (i_entries[w_idx].addr == i_ld_addr);
    assign w_data[gi]  = i_entries[w_idx].data;
  end

  always_comb begin
    o_hit  = |w_match;
    o_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[k]) begin
        o_data = w_data[k];
      end
    end
  end

endmodule

// File: rtl/store_buffer_q.sv
// Circular store buffer: accepts retiring stores, drains the oldest to the data cache and
// forwards the youngest matching store to loads in the same cycle.
module store_buffer_q
  import sb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = SB_ADDR_W,
  parameter int DATA_W     = SB_DATA_W,
  parameter int DRAIN_MODE = DRAIN_EAGER,
  parameter int HWM        = DEPTH - 1
) (
  input logic             clk,
  input logic             rst_n,
  store_buffer_q_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           w_entries [DEPTH];
  entry_t           w_head_entry;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_drain_active;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_lazy_go;
  logic              w_dc_valid;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.st_valid && !w_full;
  assign w_pop   = w_dc_valid && bus.dc_ready;

  // An offered drain stays offered until taken, even if the lazy trigger goes away.
  assign w_lazy_go  = r_drain_active || w_full || bus.drain_req || (r_count >= CNT_W'(HWM));
  assign w_dc_valid = !w_empty && ((DRAIN_MODE == DRAIN_EAGER) || w_lazy_go);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    entry_t r_entry;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_entry <= '0;
      end else if (w_push && (r_tail == PTR_W'(gi))) begin
        r_entry <= '{valid: 1'b1, addr: bus.st_addr, data: bus.st_data};
      end else if (w_pop && (r_head == PTR_W'(gi))) begin
        r_entry.valid <= 1'b0;
      end
    end
    assign w_entries[gi] = r_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_drain_active <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      r_count        <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_drain_active <= w_dc_valid && !bus.dc_ready;
    end
  end

  sb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ENTRY_T(entry_t)
  ) u_fwd (
    .i_entries(w_entries),
    .i_head   (r_head),
    .i_ld_addr(bus.ld_addr),
    .o_hit    (w_fwd_hit),
    .o_data   (w_fwd_data)
  );

  // The head slot is valid exactly when the queue is non-empty, so it doubles as the zero gate.
  assign w_head_entry = w_entries[r_head];
  assign bus.dc_addr  = w_head_entry.valid ? w_head_entry.addr : '0;
  assign bus.dc_data  = w_head_entry.valid ? w_head_entry.data : '0;

  assign bus.st_ready = !w_full;
  assign bus.dc_valid = w_dc_valid;
  assign bus.ld_hit   = bus.ld_valid && w_fwd_hit;
  assign bus.ld_data  = (bus.ld_valid && w_fwd_hit) ? w_fwd_data : '0;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.count    = r_count;

endmodule

// File: doc/store_buffer_q.md
Name: store_buffer_q

Overview:
- Parametrised FIFO store buffer between the multicycle core's memory stage and the data cache.
- Retires stores into a circular queue and drains the oldest entry to the cache over a valid/ready handshake.
- Forwards the youngest matching store to loads in the same cycle.
- Adds selectable drain policy, occupancy reporting and backpressure instead of bulk flush on full.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- DRAIN_MODE, 0, 0 = eager (drain whenever non-empty); 1 = lazy (drain only when count >= HWM, full, or drain_req).
- HWM, DEPTH-1, lazy-mode high-water mark; 1..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- st_valid  in  1  core presents a retiring store.
- st_ready  out  1  buffer accepts the store.
- st_addr  in  ADDR_W  store address.
- st_data  in  DATA_W  store data.
- ld_valid  in  1  core presents a load lookup.
- ld_addr  in  ADDR_W  load address.
- ld_hit  out  1  forwarding hit.
- ld_data  out  DATA_W  forwarded data.
- dc_valid  out  1  drain request to the data cache.
- dc_ready  in  1  cache accepts the write.
- dc_addr  out  ADDR_W  head entry address.
- dc_data  out  DATA_W  head entry data.
- drain_req  in  1  force drain (fence/idle); level-sensitive.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset: head=0, tail=0, count=0, all entry valid bits 0. Outputs: st_ready=1, dc_valid=0, ld_hit=0, ld_data=0, dc_addr=0, dc_data=0, empty=1, full=0.
- Reset assertion mid-drain: dc_valid drops immediately (async) and queued stores are discarded.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full/empty derive from count, never from pointer equality.
- Push: on st_valid && st_ready at the clock edge, write {1, st_addr, st_data} at tail; tail++ and count++.
  - st_ready = !full. It is registered-state only, with no combinational path from dc_ready.
- Pop: on dc_valid && dc_ready, clear valid[head]; head++ and count--.
  - dc_addr/dc_data always equal the head entry. They are 0 when empty.
- Drain eligibility:
  - Eager mode: dc_valid = !empty.
  - Lazy mode: dc_valid = !empty && (count >= HWM || full || drain_req).
  - Once dc_valid is asserted it holds, with stable addr/data, until accepted. A lazy condition dropping does not retract it (sticky drain_active flag, cleared on handshake).
- Simultaneous push and pop in one cycle: count unchanged and both pointers advance. This case is legal only when not full, because st_ready gates it.
- Forwarding: combinational, same cycle as ld_valid.
  - Compare ld_addr against every valid entry.
  - On multiple matches, the youngest entry (largest age = (idx - head) mod DEPTH) wins.
  - ld_hit = ld_valid && any match. ld_data = winner data, else 0.
  - An entry being popped this cycle still forwards.
  - A store being pushed this cycle is not visible until the next cycle.
- Same-address stores are not coalesced; each occupies its own entry and drains in order.
- Loads and stores may be presented in the same cycle; they are independent.

Decomposition:
- Package sb_pkg:
  - typedef sb_entry_t {valid, addr[ADDR_W], data[DATA_W]}.
  - DRAIN_EAGER=0 and DRAIN_LAZY=1 constants.
- Sub-module sb_fwd_match: combinational age-priority match.
  - Inputs: entry array, head, ld_addr.
  - Outputs: hit, data.
- Top holds the queue storage, pointers, count and drain control.

Test Plan:
- Eager, DEPTH=4: push A=0x10/0x11, B=0x20/0x22 with dc_ready=0 → count=2, dc_valid=1, dc_addr=0x10. Raise dc_ready for 2 cycles → 0x10 then 0x20 drained, empty=1.
- Fill four stores with dc_ready=0 → full=1, st_ready=0, and a fifth st_valid is not accepted. One pop → st_ready=1 next cycle.
- Forwarding: push 0x40/0xAAAA then 0x40/0xBBBB, then ld 0x40 → ld_hit=1, ld_data=0xBBBB. ld 0x44 → ld_hit=0, ld_data=0.
- Lazy, HWM=3:
  - 2 pushes → dc_valid=0.
  - Third push → dc_valid=1.
  - Alternatively, drain_req pulse with 1 entry → dc_valid=1 and held until dc_ready even after drain_req falls.
- Wrap: 10 interleaved push/pop cycles at DEPTH=4 with a simultaneous push+pop each cycle → count constant, FIFO order preserved across wrap.
- Assert rst_n=0 while dc_valid=1 with 3 entries → dc_valid=0 and count=0 immediately; after release, ld to an old address → ld_hit=0.
